// File: rtl/l2_mem_sequencer.sv
// rtl/l2_mem_sequencer.sv - L2 line-fill / writeback burst sequencer driven by an asynchronous beat strobe
module l2_mem_sequencer #(
    parameter int BURST_LENGTH = 8,
    parameter int TIMEOUT      = 255,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill_req,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [63:0]           wb_data,
    output logic                  fill_gnt,
    output logic                  wb_gnt,
    output logic [2:0]            wb_beat_idx,
    output logic                  fill_vld,
    output logic [2:0]            fill_idx,
    output logic [63:0]           fill_data,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]           mem_wdata,
    input  logic [63:0]           mem_rdata,
    input  logic                  mem_stb
);

    localparam int                    TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]            BEAT_LAST = 4'(BURST_LENGTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(63);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    state_t                state_q;
    logic                  stb_s1_q, stb_s2_q, stb_s3_q;
    logic                  beat;
    logic [3:0]            cnt_q;
    logic [TO_W-1:0]       to_q;
    logic                  last_wb_q;
    logic                  pick_wb_d;
    logic [ADDR_WIDTH-1:0] line_addr_d;

    logic                  fill_gnt_q, wb_gnt_q, fill_vld_q, done_q, err_q;
    logic                  busy_q, mem_req_q, mem_we_q;
    logic [2:0]            fill_idx_q;
    logic [63:0]           fill_data_q, mem_wdata_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    // Writeback normally wins, but a fill waiting behind a writeback grant goes next
    assign pick_wb_d   = wb_req && !(last_wb_q && fill_req);
    assign line_addr_d = (pick_wb_d ? wb_addr : fill_addr) & LINE_MASK;

    // Each edge of the strobe, in either direction, is one beat
    assign beat = stb_s2_q ^ stb_s3_q;

    // Two-flop synchroniser plus one history stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_s1_q <= 1'b0;
            stb_s2_q <= 1'b0;
            stb_s3_q <= 1'b0;
        end else begin
            stb_s1_q <= mem_stb;
            stb_s2_q <= stb_s1_q;
            stb_s3_q <= stb_s2_q;
        end
    end

    // Burst FSM: arbitration, address issue, beat counting, timeout and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            to_q        <= '0;
            last_wb_q   <= 1'b0;
            fill_gnt_q  <= 1'b0;
            wb_gnt_q    <= 1'b0;
            fill_vld_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            fill_idx_q  <= '0;
            fill_data_q <= '0;
            mem_wdata_q <= '0;
            mem_addr_q  <= '0;
        end else begin
            fill_gnt_q <= 1'b0;
            wb_gnt_q   <= 1'b0;
            fill_vld_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fill_req || wb_req) begin
                        state_q    <= ISSUE;
                        busy_q     <= 1'b1;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= pick_wb_d;
                        last_wb_q  <= pick_wb_d;
                        wb_gnt_q   <= pick_wb_d;
                        fill_gnt_q <= !pick_wb_d;
                        mem_addr_q <= line_addr_d;
                        cnt_q      <= '0;
                        to_q       <= '0;
                    end
                end
                ISSUE: begin
                    state_q <= XFER;
                    if (mem_we_q) begin
                        mem_wdata_q <= wb_data;
                    end
                end
                XFER: begin
                    // wb_data follows wb_beat_idx, so the write beat reloads one cycle after each step
                    if (mem_we_q) begin
                        mem_wdata_q <= wb_data;
                    end
                    if (beat) begin
                        to_q  <= '0;
                        cnt_q <= cnt_q + 4'd1;
                        if (!mem_we_q) begin
                            fill_data_q <= mem_rdata;
                            fill_vld_q  <= 1'b1;
                            fill_idx_q  <= cnt_q[2:0];
                        end
                        if (cnt_q == BEAT_LAST) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                        end
                    end else if (to_q == TO_LAST) begin
                        state_q   <= IDLE;
                        err_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fill_gnt    = fill_gnt_q;
    assign wb_gnt      = wb_gnt_q;
    assign wb_beat_idx = cnt_q[2:0];
    assign fill_vld    = fill_vld_q;
    assign fill_idx    = fill_idx_q;
    assign fill_data   = fill_data_q;
    assign done        = done_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule
